// File: rtl/clock_config_scheduler.sv
// clock_config_scheduler
// Round-robin arbiter between two PERIOD/DUTY requesters that drives the
// configuration inputs of a reconfigurable clock generator. A change is
// loaded one cycle after a rising edge of the fed-back generator output
// (or after TIMEOUT cycles without one), then held for MIN_DWELL output
// rises before the next request is accepted.
// Optional feature macro: CLKSCHED_VALIDATE_EN (reject PERIOD < 2 with ACK+ERR).
`timescale 1ns/1ps
module clock_config_scheduler #(
  parameter int         MIN_DWELL  = 4,
  parameter int         TIMEOUT    = 64,
  parameter logic [3:0] RST_PERIOD = 4'd2,
  parameter logic [1:0] RST_DUTY   = 2'd0
) (
  input  logic       CLK_IN,
  input  logic       RST_N,
  input  logic       REQ0_VALID,
  input  logic [3:0] REQ0_PERIOD,
  input  logic [1:0] REQ0_DUTY,
  output logic       REQ0_ACK,
  input  logic       REQ1_VALID,
  input  logic [3:0] REQ1_PERIOD,
  input  logic [1:0] REQ1_DUTY,
  output logic       REQ1_ACK,
  input  logic       CLK_OUT_FB,
  output logic [3:0] PERIOD,
  output logic [1:0] DUTY,
  output logic       BUSY,
  output logic       ERR
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int DW_W = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [DW_W-1:0] DW_LAST   = DW_W'((MIN_DWELL > 0) ? MIN_DWELL - 1 : 0);
  localparam bit              HAS_DWELL = (MIN_DWELL > 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_WAIT  = 3'd2,
    S_APPLY = 3'd3,
    S_DWELL = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_fb_q;
  logic            r_prio1;      // 1: REQ1 wins a tie next time
  logic            r_lat_id;     // requester owning the transaction in flight
  logic [3:0]      r_lat_period;
  logic [1:0]      r_lat_duty;
  logic            r_chg;        // latched setting differs from the live one
  logic [TO_W-1:0] r_to_cnt;
  logic [DW_W-1:0] r_dw_cnt;
  logic [3:0]      r_period;
  logic [1:0]      r_duty;
  logic            r_ack0;
  logic            r_ack1;
  logic            r_busy;

  logic w_rise;
  logic w_any;
  logic w_pick1;
  logic w_same;
  logic w_to_done;

  assign w_rise    = CLK_OUT_FB & ~r_fb_q;
  assign w_any     = REQ0_VALID | REQ1_VALID;
  assign w_pick1   = REQ1_VALID & (~REQ0_VALID | r_prio1);
  assign w_same    = (r_lat_period == r_period) && (r_lat_duty == r_duty);
  assign w_to_done = (r_to_cnt >= TO_LAST);

`ifdef CLKSCHED_VALIDATE_EN
  logic r_err;
  logic w_bad;
  assign w_bad = (r_lat_period < 4'd2);
  assign ERR   = r_err;
`else
  assign ERR   = 1'b0;
`endif

  assign REQ0_ACK = r_ack0;
  assign REQ1_ACK = r_ack1;
  assign PERIOD   = r_period;
  assign DUTY     = r_duty;
  assign BUSY     = r_busy;

  // Scheduler FSM: arbitration, edge-aligned apply, dwell hold; all outputs registered
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_fb_q       <= 1'b0;
      r_prio1      <= 1'b0;
      r_lat_id     <= 1'b0;
      r_lat_period <= RST_PERIOD;
      r_lat_duty   <= RST_DUTY;
      r_chg        <= 1'b0;
      r_to_cnt     <= '0;
      r_dw_cnt     <= '0;
      r_period     <= RST_PERIOD;
      r_duty       <= RST_DUTY;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_busy       <= 1'b0;
`ifdef CLKSCHED_VALIDATE_EN
      r_err        <= 1'b0;
`endif
    end else begin
      r_fb_q <= CLK_OUT_FB;
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
`ifdef CLKSCHED_VALIDATE_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_lat_id     <= w_pick1;
            r_lat_period <= w_pick1 ? REQ1_PERIOD : REQ0_PERIOD;
            r_lat_duty   <= w_pick1 ? REQ1_DUTY : REQ0_DUTY;
            r_prio1      <= ~w_pick1;
            r_to_cnt     <= '0;
            r_busy       <= 1'b1;
            r_state      <= S_CHECK;
          end
        end
        S_CHECK: begin
`ifdef CLKSCHED_VALIDATE_EN
          if (w_bad) begin
            // Rejected: acknowledge with error, live setting untouched
            r_ack0  <= ~r_lat_id;
            r_ack1  <= r_lat_id;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else
`endif
          if (w_same) begin
            // Nothing to change, so no need to align to an output edge
            r_ack0  <= ~r_lat_id;
            r_ack1  <= r_lat_id;
            r_chg   <= 1'b0;
            r_state <= S_APPLY;
          end else begin
            r_chg   <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_rise || w_to_done) begin
            r_period <= r_lat_period;
            r_duty   <= r_lat_duty;
            r_ack0   <= ~r_lat_id;
            r_ack1   <= r_lat_id;
            r_state  <= S_APPLY;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_APPLY: begin
          if (HAS_DWELL && r_chg) begin
            r_to_cnt <= '0;
            r_dw_cnt <= '0;
            r_state  <= S_DWELL;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_DWELL: begin
          if (w_rise) begin
            r_to_cnt <= '0;
            if (r_dw_cnt >= DW_LAST) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_dw_cnt <= r_dw_cnt + 1'b1;
            end
          end else if (w_to_done) begin
            // Generator output stalled: give up the hold rather than lock out requesters
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_config_scheduler.sv
// Testbench for clock_config_scheduler: directed vector table, two
// hand-written multi-cycle sequences (round-robin, reset in flight) and a
// randomized phase checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_clock_config_scheduler;

  localparam int MIN_DWELL = 4;
  localparam int TIMEOUT   = 64;
`ifdef CLKSCHED_VALIDATE_EN
  localparam bit VAL = 1'b1;
`else
  localparam bit VAL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] vld;
  logic [3:0] rper [2];
  logic [1:0] rdut [2];
  logic       ack0, ack1, fb, busy, err;
  logic [1:0] ack;
  logic [3:0] period;
  logic [1:0] duty;

  assign ack = {ack1, ack0};

  clock_config_scheduler #(
    .MIN_DWELL(MIN_DWELL), .TIMEOUT(TIMEOUT), .RST_PERIOD(4'd2), .RST_DUTY(2'd0)
  ) dut (
    .CLK_IN(clk), .RST_N(rst_n),
    .REQ0_VALID(vld[0]), .REQ0_PERIOD(rper[0]), .REQ0_DUTY(rdut[0]), .REQ0_ACK(ack0),
    .REQ1_VALID(vld[1]), .REQ1_PERIOD(rper[1]), .REQ1_DUTY(rdut[1]), .REQ1_ACK(ack1),
    .CLK_OUT_FB(fb), .PERIOD(period), .DUTY(duty), .BUSY(busy), .ERR(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_tot  = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  typedef struct {
    int         rq;
    logic [3:0] per;
    logic [1:0] dty;
    int         rise_at;   // cycle offset of the single FB rise, 0 = none
    logic [3:0] eper;
    logic [1:0] edty;
    bit         eerr;
    int         elat;      // ACK cycle minus VALID cycle
    int         eidle;     // cycles from ACK until BUSY is low
  } vec_t;

  vec_t vt [9];

  // reference model state for the random phase
  logic [3:0] m_per;
  logic [1:0] m_dty;
  bit         stop;
  bit [1:0]   rdone;

  task automatic do_reset();
    rst_n = 1'b0; vld = '0; fb = 1'b0;
    rper[0] = '0; rdut[0] = '0; rper[1] = '0; rdut[1] = '0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_period", int'(period), 2);
    chk("rst_duty", int'(duty), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk);
    while (busy && g < 1000) begin @(negedge clk); g++; end
    chk("wait_idle", int'(busy), 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n, lat, d;
    wait_idle();
    @(posedge clk); #1;
    n = cyc;
    vld[v.rq] = 1'b1; rper[v.rq] = v.per; rdut[v.rq] = v.dty; fb = 1'b0;
    lat = -1;
    for (int k = 0; k < 200 && lat < 0; k++) begin
      @(negedge clk);
      if (ack[v.rq]) begin
        lat = cyc - n;
      end else begin
        @(posedge clk); #1;
        fb = (v.rise_at > 0 && cyc - n == v.rise_at);
      end
    end
    vld[v.rq] = 1'b0;
    $display("vector %0d: ack latency %0d", idx, lat);
    chk("vec_latency", lat, v.elat);
    chk("vec_period", int'(period), int'(v.eper));
    chk("vec_duty", int'(duty), int'(v.edty));
    chk("vec_err", int'(err), int'(v.eerr));
    chk("vec_other_ack", int'(ack[1 - v.rq]), 0);
    d = 0;
    while (busy && d < 400) begin
      @(posedge clk); #1;
      d++;
      fb = d[0];
      @(negedge clk);
      if (d == 1) chk("vec_ack_one_cycle", int'(ack), 0);
    end
    chk("vec_idle_offset", d, v.eidle);
  endtask

  task automatic req_proc(input int r);
    int t;
    while (!stop) begin
      repeat ($urandom_range(0, 6)) @(posedge clk);
      if (stop) break;
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) begin
        rper[r] = m_per; rdut[r] = m_dty;
      end else begin
        rper[r] = 4'($urandom_range(0, 15)); rdut[r] = 2'($urandom_range(0, 3));
      end
      vld[r] = 1'b1;
      t = 0;
      while (t < 3000) begin
        @(negedge clk);
        if (ack[r]) break;
        t++;
      end
      chk("rand_ack_within_bound", int'(ack[r]), 1);
      if (t >= 3000) stop = 1'b1;
      #1 vld[r] = 1'b0;
    end
    rdone[r] = 1'b1;
  endtask

  task automatic fb_proc();
    int hp;
    while (!(rdone[0] && rdone[1])) begin
      if ($urandom_range(0, 9) == 0) begin
        repeat (TIMEOUT + 20) begin @(posedge clk); #1; fb = 1'b0; end
      end else begin
        hp = $urandom_range(1, 4);
        repeat (4) begin
          repeat (hp) begin @(posedge clk); #1; fb = 1'b1; end
          repeat (hp) begin @(posedge clk); #1; fb = 1'b0; end
        end
      end
    end
  endtask

  task automatic monitor();
    bit [1:0] allv;
    int       last, nacks, r;
    bit       bad;
    allv = '0; last = -1; nacks = 0;
    while (!(rdone[0] && rdone[1])) begin
      @(negedge clk);
      chk("rand_single_ack", int'(ack0 & ack1), 0);
      if (ack0 || ack1) begin
        r   = ack1 ? 1 : 0;
        bad = VAL && (rper[r] < 4'd2);
        if (!bad) begin m_per = rper[r]; m_dty = rdut[r]; end
        chk("rand_err", int'(err), int'(bad));
        // the other requester waited through the whole interval yet lost twice
        if (last == r) chk("rand_round_robin", int'(allv[1 - r]), 0);
        last = r; allv = vld; nacks++;
        if (nacks >= 60) stop = 1'b1;
      end else begin
        allv &= vld;
        chk("rand_err_quiet", int'(err), 0);
      end
      chk("rand_period", int'(period), int'(m_per));
      chk("rand_duty", int'(duty), int'(m_dty));
    end
  endtask

  initial begin
    int   order [3];
    int   at [3];
    int   cp [3];
    int   cd [3];
    int   nack, r, seen;
    bit   reenter;

    vt[0] = '{0, 4'd4,  2'd1, 2, 4'd4,  2'd1, 1'b0, 3,  2*MIN_DWELL};
    vt[1] = '{1, 4'd6,  2'd2, 0, 4'd6,  2'd2, 1'b0, 2+TIMEOUT, 2*MIN_DWELL};
    vt[2] = '{0, 4'd6,  2'd2, 0, 4'd6,  2'd2, 1'b0, 2,  1};
    vt[3] = '{1, 4'd4,  2'd3, 1, 4'd4,  2'd3, 1'b0, 2+TIMEOUT, 2*MIN_DWELL};
`ifdef CLKSCHED_VALIDATE_EN
    vt[4] = '{0, 4'd1,  2'd0, 2, 4'd4,  2'd3, 1'b1, 2,  0};
`else
    vt[4] = '{0, 4'd1,  2'd0, 2, 4'd1,  2'd0, 1'b0, 3,  2*MIN_DWELL};
`endif
    vt[5] = '{1, 4'd9,  2'd1, 5, 4'd9,  2'd1, 1'b0, 6,  2*MIN_DWELL};
    vt[6] = '{1, 4'd9,  2'd1, 0, 4'd9,  2'd1, 1'b0, 2,  1};
    vt[7] = '{0, 4'd15, 2'd3, 2, 4'd15, 2'd3, 1'b0, 3,  2*MIN_DWELL};
`ifdef CLKSCHED_VALIDATE_EN
    vt[8] = '{1, 4'd0,  2'd2, 3, 4'd15, 2'd3, 1'b1, 2,  0};
`else
    vt[8] = '{1, 4'd0,  2'd2, 3, 4'd0,  2'd2, 1'b0, 4,  2*MIN_DWELL};
`endif

    stop = 1'b0; rdone = '0;
    do_reset();
    for (int i = 0; i < 9; i++) run_vec(vt[i], i);

    // reset while waiting for an edge: no ACK, then re-presented and served
    wait_idle();
    @(posedge clk); #1;
    vld[0] = 1'b1; rper[0] = 4'd7; rdut[0] = 2'd2; fb = 1'b0;
    seen = 0;
    repeat (10) begin @(negedge clk); if (ack != 2'b00) seen = 1; end
    chk("inflight_no_ack", seen, 0);
    chk("inflight_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_period", int'(period), 2);
    chk("midrst_duty", int'(duty), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ack", int'(ack), 0);
    vld[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin @(negedge clk); if (ack != 2'b00 || busy) seen = 1; end
    chk("postrst_quiet", seen, 0);
    run_vec('{0, 4'd7, 2'd2, 2, 4'd7, 2'd2, 1'b0, 3, 2*MIN_DWELL}, 9);

    // both requesters valid from reset: REQ0, then REQ1 after the dwell, then REQ0 again
    do_reset();
    for (int i = 0; i < 3; i++) begin order[i] = -1; at[i] = 0; cp[i] = -1; cd[i] = -1; end
    @(posedge clk); #1;
    rper[0] = 4'd5; rdut[0] = 2'd1; rper[1] = 4'd7; rdut[1] = 2'd2; vld = 2'b11;
    nack = 0; reenter = 1'b0;
    for (int k = 0; k < 1500 && nack < 3; k++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        r = ack[1] ? 1 : 0;
        order[nack] = r; at[nack] = cyc; cp[nack] = int'(period); cd[nack] = int'(duty);
        nack++;
        vld[r] = 1'b0;
        if (nack == 1 && r == 0) reenter = 1'b1;
      end
      @(posedge clk); #1;
      fb = ~fb;
      if (reenter) begin
        rper[0] = 4'd3; rdut[0] = 2'd0; vld[0] = 1'b1; reenter = 1'b0;
      end
    end
    vld = '0;
    chk("rr_ack_count", nack, 3);
    chk("rr_first", order[0], 0);
    chk("rr_second", order[1], 1);
    chk("rr_third", order[2], 0);
    chk("rr_cfg0_period", cp[0], 5);
    chk("rr_cfg1_period", cp[1], 7);
    chk("rr_cfg1_duty", cd[1], 2);
    chk("rr_cfg2_period", cp[2], 3);
    chk("rr_dwell_respected", int'(at[1] - at[0] >= 2*MIN_DWELL), 1);

    // randomized phase against the transaction-level model
    do_reset();
    m_per = 4'd2; m_dty = 2'd0;
    stop = 1'b0; rdone = '0;
    fork
      req_proc(0);
      req_proc(1);
      fb_proc();
      monitor();
    join

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
